mul_mc: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier covering the RV32M MUL, MULH, MULHSU and MULHU operations.
- Sits beside the multi-cycle divider in the execute stage and uses the same start/ready handshake style.
- One product bit per cycle, to keep the critical path short.
- Returns either the low or the high 32 bits of the 64-bit product, selected by op.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_if.sv | 26 ++
 rtl/mul_mc.sv | 127 ++++++++++++
 tb/tb_mul_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared execute-stage definitions for the multi-cycle multiplier and divider.
// Decode uses these encodings to drive both units consistently.
package mul_pkg;

  localparam int MUL_DATA_WIDTH = 32;
  localparam int MUL_ITERATIONS = MUL_DATA_WIDTH;

  // Low two bits of the RV32M funct3 for each unit.
  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIV_U = 2'b01,
    REM_S = 2'b10,
    REM_U = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ITER  = 2'b01,
    ST_FINAL = 2'b10
  } mul_state_t;

  function automatic logic op_a_signed(input mul_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/mul_if.sv
// Start/ready request interface between execute-stage issue logic and the multiplier.
interface mul_if
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH
);

  logic                  start;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  mul_op_t               op;
  logic [DATA_WIDTH-1:0] result;
  logic                  ready;
  logic                  busy;

  modport master (
    output start, multiplicand, multiplier, op,
    input  result, ready, busy
  );

  modport slave (
    input  start, multiplicand, multiplier, op,
    output result, ready, busy
  );

endinterface

// File: rtl/mul_mc.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one product bit per cycle.
// Operands are reduced to magnitudes at accept; the sign is reapplied to the 64-bit product.
module mul_mc
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  mul_if.slave   bus
);

  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int ITERATIONS = DATA_WIDTH;
  localparam int CNT_W      = $clog2(ITERATIONS + 1);

  mul_state_t          state_q, state_d;
  mul_op_t             op_q, op_d;
  logic                sign_q, sign_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  zero_operand;
  logic [PROD_W-1:0]     prod;

  // Operand conditioning happens on the live bus values; it only matters on the accept edge.
  always_comb begin
    a_neg        = op_a_signed(bus.op) && bus.multiplicand[DATA_WIDTH-1];
    b_neg        = op_b_signed(bus.op) && bus.multiplier[DATA_WIDTH-1];
    // Unsigned magnitude: the most negative value maps onto itself without overflow.
    a_mag        = a_neg ? -bus.multiplicand : bus.multiplicand;
    b_mag        = b_neg ? -bus.multiplier   : bus.multiplier;
    zero_operand = (bus.multiplicand == '0) || (bus.multiplier == '0);
    prod         = sign_q ? -acc_q : acc_q;
  end

  // NOTE: every variable gets a hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    count_d  = count_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          sign_d  = a_neg ^ b_neg;
          mcand_d = {{DATA_WIDTH{1'b0}}, a_mag};
          mplr_d  = b_mag;
          acc_d   = '0;
          count_d = '0;
          ready_d = 1'b0;
          if (zero_operand) begin
            result_d = '0;
            ready_d  = 1'b1;
          end else begin
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = ST_FINAL;
        end
      end

      ST_FINAL: begin
        result_d = (op_q == MUL_LO) ? prod[DATA_WIDTH-1:0] : prod[PROD_W-1:DATA_WIDTH];
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MUL_LO;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      count_q  <= count_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_mc.sv
// Directed bench for mul_mc: a vector table for the arithmetic plus hand-written
// sequences for start-while-busy, restart-while-ready and mid-operation reset.
module tb_mul_mc;
  import mul_pkg::*;

  typedef struct {
    mul_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          edges;  // edges after accept until ready; 0 means ready right after accept
  } vec_t;

  localparam int NVEC = 18;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs [NVEC];

  mul_if #(.DATA_WIDTH(32)) bus ();

  mul_mc #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request for one edge, returns 1 time unit after that edge with start dropped
  // and the operands scrambled so late changes would show up in the result.
  task automatic issue(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.op           = op;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.op           = mul_op_t'(2'($urandom_range(0, 3)));
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (!bus.ready && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int edges;
    issue(v.op, v.a, v.b);
    if (v.edges == 0) begin
      check({tag, " fast ready"}, 32'(bus.ready), 32'd1);
      check({tag, " fast busy"}, 32'(bus.busy), 32'd0);
      check({tag, " fast result"}, bus.result, v.exp);
      @(posedge clk);
      #1;
      check({tag, " fast busy later"}, 32'(bus.busy), 32'd0);
    end else begin
      check({tag, " accept busy"}, 32'(bus.busy), 32'd1);
      check({tag, " accept ready"}, 32'(bus.ready), 32'd0);
      wait_ready(edges);
      check({tag, " latency"}, 32'(edges), 32'(v.edges));
      check({tag, " result"}, bus.result, v.exp);
      check({tag, " done busy"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int edges;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{MUL_LO, 32'd7,          32'd6,          32'h0000002A, 33};
    vecs[1]  = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 33};
    vecs[2]  = '{MUL_LO, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33};
    vecs[3]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33};
    vecs[4]  = '{MULH,   32'h80000000,   32'h80000000,   32'h40000000, 33};
    vecs[5]  = '{MULHSU, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF, 33};
    vecs[6]  = '{MULH,   32'h80000000,   32'h00000001,   32'hFFFFFFFF, 33};
    vecs[7]  = '{MULHU,  32'h00000000,   32'h12345678,   32'h00000000, 0};
    vecs[8]  = '{MULHU,  32'hFFFFFFFF,   32'h00000002,   32'h00000001, 33};
    vecs[9]  = '{MULHSU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 33};
    vecs[10] = '{MUL_LO, 32'h12345678,   32'h00000010,   32'h23456780, 33};
    vecs[11] = '{MULH,   32'hFFFFFFFE,   32'h00000003,   32'hFFFFFFFF, 33};
    vecs[12] = '{MUL_LO, 32'hFFFFFFFE,   32'h00000003,   32'hFFFFFFFA, 33};
    vecs[13] = '{MULH,   32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 33};
    vecs[14] = '{MULHSU, 32'h00000001,   32'hFFFFFFFF,   32'h00000000, 33};
    vecs[15] = '{MULH,   32'h00000001,   32'hFFFFFFFF,   32'hFFFFFFFF, 33};
    vecs[16] = '{MUL_LO, 32'h12345678,   32'h00000000,   32'h00000000, 0};
    vecs[17] = '{MUL_LO, 32'hFFFFFFFF,   32'h80000000,   32'h80000000, 33};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.op           = MUL_LO;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset result", bus.result, 32'h0);
    check("reset ready", 32'(bus.ready), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // A second start while busy is ignored; the first result arrives on schedule.
    issue(MUL_LO, 32'd3, 32'd5);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      bus.start = (k == 10);
      if (k == 10) begin
        bus.op           = MULHU;
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
      end
      @(posedge clk);
      #1;
      if (k == 10) check("ignore busy at E+10", 32'(bus.busy), 32'd1);
      if (k == 32) check("ignore busy at E+32", 32'(bus.busy), 32'd1);
    end
    check("ignore ready at E+33", 32'(bus.ready), 32'd1);
    check("ignore result at E+33", bus.result, 32'h0000000F);
    check("ignore busy at E+33", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("hold ready at E+34", 32'(bus.ready), 32'd1);

    // Restart while ready: ready drops, result holds until the new finalize.
    issue(MUL_LO, 32'd9, 32'd9);
    check("restart ready", 32'(bus.ready), 32'd0);
    check("restart busy", 32'(bus.busy), 32'd1);
    check("restart held result", bus.result, 32'h0000000F);
    wait_ready(edges);
    check("restart latency", 32'(edges), 32'd33);
    check("restart result", bus.result, 32'h00000051);

    // Reset in the middle of an operation abandons it.
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset result", bus.result, 32'h0);
    check("midreset ready", 32'(bus.ready), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset ready", 32'(bus.ready), 32'd0);
    check("post-reset busy", 32'(bus.busy), 32'd0);
    run_vec("post-reset", '{MUL_LO, 32'd2, 32'd3, 32'h00000006, 33});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
